// File: rtl/early_detection_debouncing.sv
// Early-detection button debouncer: the output follows the first sampled edge of btn_i,
// then btn_i is ignored for N = DELAY_NS / CLK_PERIOD_NS cycles so bounce cannot re-toggle it.
module early_detection_debouncing #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int DELAY_NS      = 20_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic debounced_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int N     = DELAY_NS / CLK_PERIOD_NS;
    localparam int CNT_W = (N < 1) ? 1 : $clog2(N + 1);
    localparam logic [CNT_W-1:0] RELOAD = (N < 1) ? '0 : CNT_W'(N - 1);

    if (N < 1) begin : g_bad_n
        $error("early_detection_debouncing: DELAY_NS / CLK_PERIOD_NS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    logic btn_s;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;

        // Shift toward the MSB; the MSB is the fully synchronized level.
        always_comb begin
            sync_d = (sync_q << 1) | SYNC_STAGES'(btn_i);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign btn_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign btn_s = btn_i;
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             debounced_q, debounced_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        debounced_d = 1'b0;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (btn_s) begin
                    state_d     = ST_WAIT1;
                    cnt_d       = RELOAD;
                    debounced_d = 1'b1;
                    rise_d      = 1'b1;
                end
            end
            ST_WAIT1: begin
                debounced_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                debounced_d = 1'b1;
                if (!btn_s) begin
                    state_d     = ST_WAIT0;
                    cnt_d       = RELOAD;
                    debounced_d = 1'b0;
                    fall_d      = 1'b1;
                end
            end
            ST_WAIT0: begin
                // Expiry is unconditional; ZERO re-checks the input next cycle.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_ZERO;
                end
            end
            default: begin
                state_d = ST_ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ZERO;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign debounced_o = debounced_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;

endmodule

// File: tb/tb_early_detection_debouncing.sv
// Scoreboard bench for early_detection_debouncing: one instance with N=10 and one with N=1,
// both driven by the same button/reset and checked every cycle against a lockout model.
module tb_early_detection_debouncing;

    logic clk;
    logic rst_i;
    logic btn_i;
    logic deb10, rise10, fall10;
    logic deb1, rise1, fall1;

    early_detection_debouncing #(
        .CLK_PERIOD_NS(10),
        .DELAY_NS(100),
        .SYNC_STAGES(2)
    ) dut10 (
        .clk_i(clk),
        .rst_i(rst_i),
        .btn_i(btn_i),
        .debounced_o(deb10),
        .rise_tick_o(rise10),
        .fall_tick_o(fall10)
    );

    early_detection_debouncing #(
        .CLK_PERIOD_NS(10),
        .DELAY_NS(10),
        .SYNC_STAGES(2)
    ) dut1 (
        .clk_i(clk),
        .rst_i(rst_i),
        .btn_i(btn_i),
        .debounced_o(deb1),
        .rise_tick_o(rise1),
        .fall_tick_o(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] e10;
        logic [2:0] e1;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0: N=10, index 1: N=1
    int   nv[2] = '{10, 1};
    logic m_s0[2];
    logic m_s1[2];
    logic m_lvl[2];
    int   m_lock[2];

    // Observation bookkeeping
    int   cyc = 0;
    int   rise10_n, fall10_n, hi10_n, fall10_at;
    int   n1_tr, last1, min1;
    logic prev1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input int i, input logic b, input logic r, output logic [2:0] e);
        logic bs, rs, fl;
        rs = 1'b0;
        fl = 1'b0;
        if (r) begin
            m_s0[i]   = 1'b0;
            m_s1[i]   = 1'b0;
            m_lvl[i]  = 1'b0;
            m_lock[i] = 0;
        end else begin
            bs      = m_s1[i];
            m_s1[i] = m_s0[i];
            m_s0[i] = b;
            if (m_lock[i] > 0) begin
                m_lock[i]--;
            end else if (bs != m_lvl[i]) begin
                m_lvl[i]  = bs;
                rs        = bs;
                fl        = ~bs;
                m_lock[i] = nv[i];
            end
        end
        e = {m_lvl[i], rs, fl};
    endtask

    task automatic clr();
        rise10_n  = 0;
        fall10_n  = 0;
        hi10_n    = 0;
        fall10_at = -1;
        n1_tr     = 0;
        last1     = -1;
        min1      = 1000;
    endtask

    task automatic cycle(input logic b, input logic r);
        exp_t       x;
        logic [2:0] a, c;
        btn_i = b;
        rst_i = r;
        model_step(0, b, r, a);
        model_step(1, b, r, c);
        x.e10 = a;
        x.e1  = c;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        x = sb_q.pop_front();
        chk("n10_out", 32'({deb10, rise10, fall10}), 32'(x.e10));
        chk("n1_out", 32'({deb1, rise1, fall1}), 32'(x.e1));
        chk("n10_ticks_exclusive", 32'(rise10 & fall10), 32'd0);
        chk("n1_ticks_exclusive", 32'(rise1 & fall1), 32'd0);
        rise10_n += int'(rise10);
        fall10_n += int'(fall10);
        hi10_n   += int'(deb10);
        if (fall10 && fall10_at < 0) fall10_at = cyc;
        if (deb1 !== prev1) begin
            n1_tr++;
            if (last1 >= 0 && (cyc - last1) < min1) min1 = cyc - last1;
            last1 = cyc;
        end
        prev1 = deb1;
    endtask

    task automatic hold(input logic b, input int n);
        repeat (n) cycle(b, 1'b0);
    endtask

    int t0;

    initial begin
        btn_i = 1'b0;
        rst_i = 1'b1;
        prev1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_s0[i] = 1'b0; m_s1[i] = 1'b0; m_lvl[i] = 1'b0; m_lock[i] = 0;
        end
        clr();

        // Reset, then idle low
        repeat (3) cycle(1'b0, 1'b1);
        chk("rst_outputs", 32'({deb10, rise10, fall10}), 32'd0);
        clr();
        hold(1'b0, 20);
        chk("idle_no_rise", 32'(rise10_n), 32'd0);
        chk("idle_low", 32'(hi10_n), 32'd0);

        // Rise latency: sampled at posedge k, visible at k+2
        cycle(1'b1, 1'b0);
        chk("lat_k_deb", 32'(deb10), 32'd0);
        cycle(1'b1, 1'b0);
        chk("lat_k1_deb", 32'(deb10), 32'd0);
        cycle(1'b1, 1'b0);
        chk("lat_k2_deb", 32'(deb10), 32'd1);
        chk("lat_k2_rise", 32'(rise10), 32'd1);
        cycle(1'b1, 1'b0);
        chk("lat_k3_rise", 32'(rise10), 32'd0);
        hold(1'b1, 15);

        // Falling bounce from ONE
        clr();
        t0 = cyc;
        hold(1'b0, 5);
        hold(1'b1, 5);
        hold(1'b0, 100);
        chk("fall_bounce_falls", 32'(fall10_n), 32'd1);
        chk("fall_bounce_rises", 32'(rise10_n), 32'd0);
        chk("fall_bounce_latency", 32'(fall10_at - t0), 32'd3);

        // Rising bounce from ZERO, confined inside the lockout window
        clr();
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 100);
        chk("rise_bounce_rises", 32'(rise10_n), 32'd1);
        chk("rise_bounce_falls", 32'(fall10_n), 32'd0);
        chk("rise_bounce_high", 32'(hi10_n), 32'd106);
        hold(1'b0, 30);

        // Single-cycle glitch in ZERO stretches to N+1 cycles
        clr();
        cycle(1'b1, 1'b0);
        hold(1'b0, 30);
        chk("glitch_high_cycles", 32'(hi10_n), 32'd11);
        chk("glitch_rises", 32'(rise10_n), 32'd1);
        chk("glitch_falls", 32'(fall10_n), 32'd1);

        // Reset in the middle of WAIT1
        clr();
        hold(1'b1, 3);
        chk("wait1_entered", 32'(deb10), 32'd1);
        hold(1'b1, 4);
        cycle(1'b1, 1'b1);
        chk("midwait_rst_deb", 32'(deb10), 32'd0);
        chk("midwait_rst_fall", 32'(fall10), 32'd0);
        // Back in ZERO with no lockout: the held button rises after the synchronizer refills
        hold(1'b1, 2);
        chk("post_rst_still_low", 32'(deb10), 32'd0);
        cycle(1'b1, 1'b0);
        chk("post_rst_rise", 32'(rise10), 32'd1);
        hold(1'b0, 30);

        // N=1 instance: button toggling every cycle, then every two cycles
        clr();
        prev1 = deb1;
        for (int i = 0; i < 40; i++) cycle(logic'(i % 2 == 0), 1'b0);
        chk("n1_toggle_moves", 32'(n1_tr > 0), 32'd1);
        chk("n1_toggle_spacing", 32'(min1 >= 2), 32'd1);
        clr();
        prev1 = deb1;
        repeat (10) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        chk("n1_pair_min_spacing", 32'(min1), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
